ip_seq: RTL and testbench
=========================

Name: ip_seq

Overview:
- Registered instruction-pointer sequencer with an integrated return-address stack.
- Generalises the combinational next-IP select:
  - holds IP in a register;
  - adds call/return with a parameterised-depth stack, conditional branch, fetch-stall handshake and sticky stack-fault flags.
- Sits between the decoder and instruction memory address port.
- Replaces the external rstack_top path for control flow.

Parameters:
- IADDR_WIDTH, 10: instruction address width.
- RS_DEPTH, 8: return-stack entries (>=2, power of two).
- RESET_VECTOR, 0: IP after reset and target of return-underflow.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- advance  input  1  current instruction retires this cycle; IP updates only when high.
- ip_op  input  3  control op: 0 NEXT, 1 JMP_IMM, 2 BRZ_IMM, 3 CALL_IMM, 4 RET, 5 JMP_TOS, 6 CALL_TOS, 7 reserved (= NEXT).
- ip_imm  input  IADDR_WIDTH  immediate target.
- tos  input  IADDR_WIDTH  data-stack top (caller truncates).
- tos_is_zero  input  1  data-stack top equals zero.
- flag_clr  input  1  clears sticky fault flags.
- ip  output  IADDR_WIDTH  current instruction address (registered).
- ip_inc  output  IADDR_WIDTH  ip+1, combinational from ip.
- rs_top  output  IADDR_WIDTH  top return entry; RESET_VECTOR when empty.
- rs_depth  output  clog2(RS_DEPTH+1)  valid entries.
- rs_overflow  output  1  sticky: a call was issued while the stack was full.
- rs_underflow  output  1  sticky: a return was issued while the stack was empty.

Behaviour:
- Reset (rst_n low, async):
  - ip=RESET_VECTOR; rs_depth=0; both flags=0.
  - Stack storage contents need not be reset.
  - Reset mid-operation abandons any in-flight op. No stack write occurs in the reset cycle.
- advance low: ip, stack, depth and flags hold. The exception is flag_clr, which acts regardless of advance.
- advance high, next ip by op (all arithmetic modulo 2^IADDR_WIDTH; ip_inc of all-ones wraps to 0):
  - NEXT / 7: ip_inc.
  - JMP_IMM: ip_imm.
  - BRZ_IMM: ip_imm if tos_is_zero, else ip_inc.
  - CALL_IMM: ip_imm; push ip_inc.
  - RET: rs_top; pop.
  - JMP_TOS: tos.
  - CALL_TOS: tos; push ip_inc.
- Latency: new ip is visible the cycle after the advance edge. rs_top and rs_depth reflect a push/pop on the same edge.
- Push when depth<RS_DEPTH: write at the top pointer, depth+1.
- Push when full:
  - circular overwrite of the oldest entry; the pushed value becomes the top;
  - depth stays RS_DEPTH; rs_overflow set.
- Pop when depth>0: depth-1; the returned address is the pre-pop rs_top.
- Pop when empty:
  - next ip=RESET_VECTOR; depth stays 0; rs_underflow set.
- Stack is implemented as a circular buffer with a top pointer of clog2(RS_DEPTH) bits plus the depth counter. No simultaneous push and pop is possible, since each op does at most one.
- Flags:
  - set on the fault edge; cleared by flag_clr on the next edge.
  - If a fault and flag_clr occur on the same edge, set wins.
- ip_inc and rs_top are combinational from registers only. No input-to-output combinational path.

Test Plan:
- Reset then 3 cycles of advance with NEXT -> ip 0,1,2,3; rs_depth=0; flags 0. Drop advance for 2 cycles -> ip holds at 3.
- ip=0x005, CALL_IMM ip_imm=0x100 -> ip=0x100, rs_top=0x006, depth=1. Then RET -> ip=0x006, depth=0.
- BRZ_IMM ip_imm=0x040 at ip=0x010:
  - with tos_is_zero=1 -> ip=0x040;
  - repeat from ip=0x010 with tos_is_zero=0 -> ip=0x011.
- RS_DEPTH=8: 9 CALL_TOS from ip=1..9 with tos=0x200 -> depth=8; rs_overflow=1 after the 9th call.
  - Then 8 RETs return 0x00A,0x009,...,0x003; the oldest entry (0x002) is lost.
  - A 9th RET -> ip=RESET_VECTOR; rs_underflow=1.
- ip=0x3FF, NEXT -> ip=0x000 (wrap). Pulse flag_clr with advance low -> both flags clear next cycle.
- Assert rst_n low mid-CALL with advance high -> ip=RESET_VECTOR immediately (async); depth=0; no push recorded after release.

Source files
------------

// File: rtl/ip_seq.sv
// Registered instruction-pointer sequencer with a circular return-address stack,
// conditional branch, stall (advance) handshake and sticky stack-fault flags.
module ip_seq #(
  parameter int                     IADDR_WIDTH  = 10,
  parameter int                     RS_DEPTH     = 8,
  parameter logic [IADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            advance,
  input  logic [2:0]                      ip_op,
  input  logic [IADDR_WIDTH-1:0]          ip_imm,
  input  logic [IADDR_WIDTH-1:0]          tos,
  input  logic                            tos_is_zero,
  input  logic                            flag_clr,
  output logic [IADDR_WIDTH-1:0]          ip,
  output logic [IADDR_WIDTH-1:0]          ip_inc,
  output logic [IADDR_WIDTH-1:0]          rs_top,
  output logic [$clog2(RS_DEPTH+1)-1:0]   rs_depth,
  output logic                            rs_overflow,
  output logic                            rs_underflow
);

  localparam int PTR_W   = $clog2(RS_DEPTH);
  localparam int DEPTH_W = $clog2(RS_DEPTH+1);

  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JMP_IMM  = 3'd1,
    OP_BRZ_IMM  = 3'd2,
    OP_CALL_IMM = 3'd3,
    OP_RET      = 3'd4,
    OP_JMP_TOS  = 3'd5,
    OP_CALL_TOS = 3'd6,
    OP_RSVD     = 3'd7
  } op_e;

  logic [IADDR_WIDTH-1:0] stack_mem [RS_DEPTH];
  logic [PTR_W-1:0]       top_ptr;
  logic [DEPTH_W-1:0]     depth;

  op_e                    op;
  logic [IADDR_WIDTH-1:0] ip_next;
  logic                   push;
  logic                   pop;
  logic                   is_full;
  logic                   is_empty;
  logic                   do_push;
  logic                   do_pop;
  logic                   ovf_event;
  logic                   unf_event;

  assign op       = op_e'(ip_op);
  assign ip_inc   = ip + IADDR_WIDTH'(1);
  assign is_full  = (depth == DEPTH_W'(RS_DEPTH));
  assign is_empty = (depth == '0);
  assign rs_top   = is_empty ? RESET_VECTOR : stack_mem[top_ptr];
  assign rs_depth = depth;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ip_next = ip_inc;
    push    = 1'b0;
    pop     = 1'b0;
    case (op)
      OP_JMP_IMM:  ip_next = ip_imm;
      OP_BRZ_IMM:  ip_next = tos_is_zero ? ip_imm : ip_inc;
      OP_CALL_IMM: begin ip_next = ip_imm; push = 1'b1; end
      OP_RET:      begin ip_next = rs_top; pop  = 1'b1; end
      OP_JMP_TOS:  ip_next = tos;
      OP_CALL_TOS: begin ip_next = tos;    push = 1'b1; end
      default:     ip_next = ip_inc;
    endcase
  end

  assign do_push   = advance & push;
  assign do_pop    = advance & pop;
  assign ovf_event = do_push & is_full;
  assign unf_event = do_pop & is_empty;

  // NOTE: sequential state uses non-blocking assignments; stack_mem is written
  // only outside reset and is deliberately not cleared, since depth alone
  // decides which entries are valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip           <= RESET_VECTOR;
      top_ptr      <= '0;
      depth        <= '0;
      rs_overflow  <= 1'b0;
      rs_underflow <= 1'b0;
    end else begin
      if (advance) ip <= ip_next;

      // A push when full lands on the oldest slot, which sits just above the top.
      if (do_push) begin
        stack_mem[top_ptr + PTR_W'(1)] <= ip_inc;
        top_ptr                        <= top_ptr + PTR_W'(1);
        if (!is_full) depth <= depth + DEPTH_W'(1);
      end else if (do_pop && !is_empty) begin
        top_ptr <= top_ptr - PTR_W'(1);
        depth   <= depth - DEPTH_W'(1);
      end

      // A fault on the same edge as flag_clr wins over the clear.
      if (ovf_event)     rs_overflow  <= 1'b1;
      else if (flag_clr) rs_overflow  <= 1'b0;
      if (unf_event)     rs_underflow <= 1'b1;
      else if (flag_clr) rs_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ip_seq.sv
// Directed bench for ip_seq: a vector table for single-cycle ops plus
// hand-written sequences for stack overflow/underflow, flag clear and async reset.
module tb_ip_seq;

  localparam int AW = 10;

  localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, BRZ = 3'd2, CALLI = 3'd3,
                         RET  = 3'd4, JTOS = 3'd5, CALLT = 3'd6, RSVD = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          advance = 1'b0;
  logic [2:0]    ip_op = 3'd0;
  logic [AW-1:0] ip_imm = '0;
  logic [AW-1:0] tos = '0;
  logic          tos_is_zero = 1'b0;
  logic          flag_clr = 1'b0;
  logic [AW-1:0] ip;
  logic [AW-1:0] ip_inc;
  logic [AW-1:0] rs_top;
  logic [3:0]    rs_depth;
  logic          rs_overflow;
  logic          rs_underflow;

  int checks = 0;
  int errors = 0;

  ip_seq #(.IADDR_WIDTH(AW), .RS_DEPTH(8), .RESET_VECTOR(10'h000)) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .ip_op(ip_op),
    .ip_imm(ip_imm), .tos(tos), .tos_is_zero(tos_is_zero), .flag_clr(flag_clr),
    .ip(ip), .ip_inc(ip_inc), .rs_top(rs_top), .rs_depth(rs_depth),
    .rs_overflow(rs_overflow), .rs_underflow(rs_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic       adv;
    logic [2:0] op;
    logic [9:0] imm;
    logic [9:0] tos;
    logic       tz;
    logic       clr;
    logic [9:0] e_ip;
    logic [9:0] e_top;
    logic [3:0] e_dep;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_state(input string name, input logic [9:0] e_ip, input logic [9:0] e_top,
                              input logic [3:0] e_dep, input logic e_ovf, input logic e_unf);
    check({name, ".ip"},     32'(ip),           32'(e_ip));
    check({name, ".ip_inc"}, 32'(ip_inc),       32'(10'(e_ip + 10'd1)));
    check({name, ".top"},    32'(rs_top),       32'(e_top));
    check({name, ".depth"},  32'(rs_depth),     32'(e_dep));
    check({name, ".ovf"},    32'(rs_overflow),  32'(e_ovf));
    check({name, ".unf"},    32'(rs_underflow), 32'(e_unf));
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled #1 after the next one.
  task automatic drive(input logic adv, input logic [2:0] op, input logic [9:0] imm,
                       input logic [9:0] t, input logic tz, input logic clr);
    advance = adv; ip_op = op; ip_imm = imm; tos = t; tos_is_zero = tz; flag_clr = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string n, input logic adv, input logic [2:0] op,
                              input logic [9:0] imm, input logic [9:0] t, input logic tz,
                              input logic [9:0] e_ip, input logic [9:0] e_top,
                              input logic [3:0] e_dep);
    vec_t v;
    v.name = n; v.adv = adv; v.op = op; v.imm = imm; v.tos = t; v.tz = tz; v.clr = 1'b0;
    v.e_ip = e_ip; v.e_top = e_top; v.e_dep = e_dep; v.e_ovf = 1'b0; v.e_unf = 1'b0;
    vecs.push_back(v);
  endfunction

  initial begin
    //   name        adv op     imm     tos     tz    e_ip    e_top   e_dep
    add("next1",     1, NEXT,  10'h0,  10'h0,  0, 10'h001, 10'h000, 4'd0);
    add("next2",     1, NEXT,  10'h0,  10'h0,  0, 10'h002, 10'h000, 4'd0);
    add("next3",     1, NEXT,  10'h0,  10'h0,  0, 10'h003, 10'h000, 4'd0);
    add("stall1",    0, NEXT,  10'h0,  10'h0,  0, 10'h003, 10'h000, 4'd0);
    add("stall2",    0, JMP,   10'h155,10'h0,  0, 10'h003, 10'h000, 4'd0);
    add("jmp5",      1, JMP,   10'h005,10'h0,  0, 10'h005, 10'h000, 4'd0);
    add("call100",   1, CALLI, 10'h100,10'h0,  0, 10'h100, 10'h006, 4'd1);
    add("ret",       1, RET,   10'h0,  10'h0,  0, 10'h006, 10'h000, 4'd0);
    add("jmp10a",    1, JMP,   10'h010,10'h0,  0, 10'h010, 10'h000, 4'd0);
    add("brz_take",  1, BRZ,   10'h040,10'h0,  1, 10'h040, 10'h000, 4'd0);
    add("jmp10b",    1, JMP,   10'h010,10'h0,  0, 10'h010, 10'h000, 4'd0);
    add("brz_skip",  1, BRZ,   10'h040,10'h0,  0, 10'h011, 10'h000, 4'd0);
    add("jtos",      1, JTOS,  10'h0,  10'h123,1, 10'h123, 10'h000, 4'd0);
    add("rsvd",      1, RSVD,  10'h2AA,10'h0,  0, 10'h124, 10'h000, 4'd0);
    add("jmp3ff",    1, JMP,   10'h3FF,10'h0,  0, 10'h3FF, 10'h000, 4'd0);
    add("wrap",      1, NEXT,  10'h0,  10'h0,  0, 10'h000, 10'h000, 4'd0);

    rst_n = 1'b0;
    #12;
    expect_state("reset", 10'h000, 10'h000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].adv, vecs[i].op, vecs[i].imm, vecs[i].tos, vecs[i].tz, vecs[i].clr);
      expect_state(vecs[i].name, vecs[i].e_ip, vecs[i].e_top, vecs[i].e_dep,
                   vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Nine calls from ip=1..9 push 2..10; the ninth overwrites the oldest (2).
    for (int k = 1; k <= 9; k++) begin
      drive(1, JMP, 10'(k), 10'h0, 0, 0);
      drive(1, CALLT, 10'h0, 10'h200, 0, 0);
      expect_state($sformatf("call%0d", k), 10'h200, 10'(k + 1),
                   4'((k > 8) ? 8 : k), (k == 9), 1'b0);
    end

    // Eight returns yield 0x00A down to 0x003.
    for (int r = 0; r < 8; r++) begin
      drive(1, RET, 10'h0, 10'h0, 0, 0);
      expect_state($sformatf("ret%0d", r), 10'(10 - r), (r < 7) ? 10'(9 - r) : 10'h000,
                   4'(7 - r), 1'b1, 1'b0);
    end

    drive(1, RET, 10'h0, 10'h0, 0, 0);
    expect_state("ret_empty", 10'h000, 10'h000, 4'd0, 1'b1, 1'b1);

    drive(0, NEXT, 10'h0, 10'h0, 0, 1);
    expect_state("clr_stalled", 10'h000, 10'h000, 4'd0, 1'b0, 1'b0);

    // Underflow on the same edge as flag_clr keeps the flag set.
    drive(1, RET, 10'h0, 10'h0, 0, 1);
    expect_state("set_wins", 10'h000, 10'h000, 4'd0, 1'b0, 1'b1);
    drive(0, NEXT, 10'h0, 10'h0, 0, 1);
    expect_state("clr_again", 10'h000, 10'h000, 4'd0, 1'b0, 1'b0);

    // Async reset in the middle of a call cycle.
    drive(1, JMP, 10'h050, 10'h0, 0, 0);
    drive(1, CALLI, 10'h1AA, 10'h0, 0, 0);
    expect_state("pre_rst", 10'h1AA, 10'h051, 4'd1, 1'b0, 1'b0);
    advance = 1'b1; ip_op = CALLI; ip_imm = 10'h2BB; flag_clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("async_rst", 10'h000, 10'h000, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, NEXT, 10'h0, 10'h0, 0, 0);
    expect_state("post_rst", 10'h000, 10'h000, 4'd0, 1'b0, 1'b0);
    drive(1, RET, 10'h0, 10'h0, 0, 0);
    expect_state("post_rst_ret", 10'h000, 10'h000, 4'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
